imem_fetch_unit: RTL and testbench
==================================

# imem_fetch_unit

Parametrised, synchronous instruction memory with a fetch handshake, sitting between the PC/fetch stage and the decode stage of the pipelined processor. After reset, a sequencer clears storage to a NOP word and then accepts program loading through a write port. It then serves byte-addressed, word-aligned instruction fetches with one-cycle latency and backpressure. It replaces the asynchronous 8-bit, file-initialised memory with a clocked, width- and depth-configurable block.

## Interface
- INSTR_W, 32, instruction width in bits; multiple of 8.
- DEPTH, 64, number of instruction words; power of 2.
- ADDR_W, 10, byte-address width of fetch_addr.
- NOP_WORD, 32'h0000_0013, value written during clear and returned on fault.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_valid  in  1  fetch request present.
- fetch_addr  in  ADDR_W  byte address of the instruction.
- fetch_ready  out  1  request accepted this cycle when high with fetch_valid.
- instr_valid  out  1  response register holds a result.
- instr_data  out  INSTR_W  fetched instruction.
- instr_fault  out  1  response is an out-of-range or misaligned fetch.
- instr_ready  in  1  decode consumes the response.
- prog_valid  in  1  program-write request.
- prog_addr  in  $clog2(DEPTH)  word index to write.
- prog_data  in  INSTR_W  word to write.
- prog_ready  out  1  write accepted this cycle.
- prog_done  in  1  end-of-load strobe.
- mode  out  2  sequencer state: CLEAR=0, LOAD=1, RUN=2.

## Operation
- BYTES = INSTR_W/8, word index = fetch_addr >> log2(BYTES).
- Sequencer states:
  - CLEAR: a counter runs 0..DEPTH-1 and writes NOP_WORD to one word per cycle. After writing word DEPTH-1, the sequencer goes to LOAD.
  - LOAD: prog_ready=1. Each cycle with prog_valid high writes mem[prog_addr]=prog_data. prog_done moves the sequencer to RUN; a write in the same cycle as prog_done is still performed.
  - RUN: prog_ready=0 and prog_valid is ignored.
  - prog_done outside LOAD is ignored. No transition leaves RUN except reset.
- Fetch:
  - fetch_ready = (mode==RUN) && (!instr_valid || instr_ready).
  - On accept, the response register loads mem[index] and instr_valid is set.
  - If instr_ready is high with no new accept, instr_valid clears.
  - While instr_valid && !instr_ready, instr_data and instr_fault hold stable.
- Reset (asserted at any time, including mid-CLEAR, mid-LOAD or with a pending response):
  - mode=CLEAR, counter=0, instr_valid=0, instr_data=0, instr_fault=0, fetch_ready=0, prog_ready=0.
  - Contents are re-cleared once reset is released.

## Timing
- Fetch latency: accept at edge N gives instr_valid/instr_data valid after edge N, so visible in cycle N+1. Throughput is 1 per cycle while instr_ready is high.
- CLEAR lasts exactly DEPTH cycles after reset deassertion. mode reads LOAD in cycle DEPTH+1.
- A prog write at edge N is visible to a fetch accepted at edge N+1 or later. Fetches cannot occur in LOAD.
- prog_done sampled at edge N gives mode=RUN and fetch_ready may be high in cycle N+1.

## Configuration
- IMEM_BOUNDS_CHECK_EN defined:
  - A fetch with nonzero low log2(BYTES) address bits, or with word index >= DEPTH, returns instr_data=NOP_WORD and instr_fault=1.
  - Latency and handshake are unchanged.
- IMEM_BOUNDS_CHECK_EN undefined:
  - Low address bits are ignored and the index is taken modulo DEPTH (low bits only).
  - instr_fault is tied to 0.

## Structure
- Package imem_pkg holds:
  - the mode_t enum (CLEAR, LOAD, RUN);
  - the default NOP_WORD constant;
  - a helper function for the log2 byte offset.
- Sub-module imem_array: 1-read/1-write synchronous storage, DEPTH x INSTR_W, with read enable and output register. The top holds the sequencer, clear counter, write-port mux (clear vs prog) and fetch handshake.

## Test plan
- Reset release, no stimulus: mode=0 for 64 cycles, then mode=1; all outputs 0 during reset.
- LOAD writes word 0=32'h00500093 and word 1=32'h00a00113, then prog_done. Fetch 0x000 and 0x004 give the data back-to-back, one cycle after each accept.
- Fetch unwritten address 0x008 after load gives 32'h00000013 with instr_fault=0.
- Hold instr_ready=0 for 3 cycles after a fetch: fetch_ready=0, and instr_data stays stable and valid until instr_ready=1.
- Fetch 0x100 and 0x002:
  - with IMEM_BOUNDS_CHECK_EN: NOP_WORD with instr_fault=1;
  - without it: word 0 contents with instr_fault=0.
- Assert reset during RUN with a pending response: instr_valid drops immediately, mode=0, and a later fetch of 0x000 after reload returns the newly loaded word.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory fetch unit.
`default_nettype none

package imem_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_RUN   = 2'd2
  } mode_t;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  // Number of byte-offset bits inside one instruction word.
  function automatic int imem_off_bits(input int instr_w);
    return $clog2(instr_w / 8);
  endfunction

endpackage : imem_pkg

`default_nettype wire

// File: rtl/imem_array.sv
// imem_array: 1R/1W synchronous storage with read enable and a resettable output register.
`default_nettype none

module imem_array #(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 64,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic               i_re,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;

  // Storage itself is not reset; the sequencer clears it after reset release.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : imem_array

`default_nettype wire

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: clear/load/run sequencer and fetch handshake around imem_array.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN (misaligned/out-of-range fetch fault).
`default_nettype none

module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int                 INSTR_W  = 32,
  parameter int                 DEPTH    = 64,
  parameter int                 ADDR_W   = 10,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(IMEM_NOP_WORD)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_ready,
  output logic                     instr_valid,
  output logic [INSTR_W-1:0]       instr_data,
  output logic                     instr_fault,
  input  logic                     instr_ready,
  input  logic                     prog_valid,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [INSTR_W-1:0]       prog_data,
  output logic                     prog_ready,
  input  logic                     prog_done,
  output logic [1:0]               mode
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OFF_W = imem_off_bits(INSTR_W);

  localparam logic [1:0] S_CLEAR = MODE_CLEAR;
  localparam logic [1:0] S_LOAD  = MODE_LOAD;
  localparam logic [1:0] S_RUN   = MODE_RUN;

  logic [1:0]         r_mode;
  logic [AW-1:0]      r_cnt;
  logic               r_valid;
  logic               w_accept;
  logic               w_we;
  logic [AW-1:0]      w_waddr;
  logic [INSTR_W-1:0] w_wdata;
  logic [AW-1:0]      w_index;
  logic [INSTR_W-1:0] w_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= S_CLEAR;
      r_cnt  <= '0;
    end else begin
      case (r_mode)
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_mode <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (prog_done) begin
            r_mode <= S_RUN;
          end
        end
        S_RUN:   r_mode <= S_RUN;
        default: r_mode <= S_CLEAR;
      endcase
    end
  end

  // Write port: the clear counter owns it in CLEAR, the program port in LOAD.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = prog_addr;
    w_wdata = prog_data;
    if (r_mode == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_cnt;
      w_wdata = NOP_WORD;
    end else if (r_mode == S_LOAD) begin
      w_we    = prog_valid;
    end
  end

  assign mode        = r_mode;
  assign prog_ready  = (r_mode == S_LOAD);
  assign fetch_ready = (r_mode == S_RUN) && (!r_valid || instr_ready);
  assign w_accept    = fetch_valid && fetch_ready;
  assign instr_valid = r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (instr_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  logic [ADDR_W-1:0] w_word;
  logic              w_fault;
  logic              r_fault;

  assign w_word  = fetch_addr >> OFF_W;
  assign w_index = w_word[AW-1:0];
  assign w_fault = (|(fetch_addr & OFF_MASK)) || (32'(w_word) >= 32'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= w_fault;
    end
  end

  // The fault flag is registered with the read, so the substitution stays stable under backpressure.
  assign instr_fault = r_fault;
  assign instr_data  = r_fault ? NOP_WORD : w_rdata;
`else
  logic w_unused_addr;

  assign w_index       = fetch_addr[OFF_W +: AW];
  assign w_unused_addr = ^fetch_addr;
  assign instr_fault   = 1'b0;
  assign instr_data    = w_rdata;
`endif

  imem_array #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_array (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_accept),
    .i_raddr (w_index),
    .o_rdata (w_rdata)
  );

endmodule : imem_fetch_unit

`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed, table-driven checks of the clear/load/run flow and fetch handshake.
`default_nettype none

module tb_imem_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h00a0_0113;
`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic [31:0] OOR_D = NOP;
  localparam logic        OOR_F = 1'b1;
`else
  localparam logic [31:0] OOR_D = W0;
  localparam logic        OOR_F = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [9:0]  fetch_addr = '0;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic        instr_fault;
  logic        instr_ready = 1'b1;
  logic        prog_valid = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        prog_ready;
  logic        prog_done = 1'b0;
  logic [1:0]  mode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_fault (instr_fault),
    .instr_ready (instr_ready),
    .prog_valid  (prog_valid),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_ready  (prog_ready),
    .prog_done   (prog_done),
    .mode        (mode)
  );

  typedef struct {
    logic        fv;
    logic [9:0]  addr;
    logic        rdy;
    logic        exp_fr;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_f;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at the negedge where reset was released; counts edges until LOAD.
  task automatic wait_clear(input bit pulse_done, output int cycles);
    cycles = 0;
    while (mode != 2'd1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (pulse_done && cycles == 10) prog_done = 1'b1;
      if (pulse_done && cycles == 20) prog_done = 1'b0;
      if (cycles < 64) chk("mode_clear", 32'(mode), 32'd0);
    end
  endtask

  task automatic prog_write(input logic [5:0] a, input logic [31:0] d, input logic done);
    prog_valid = 1'b1;
    prog_addr  = a;
    prog_data  = d;
    prog_done  = done;
    @(negedge clk);
    prog_valid = 1'b0;
    prog_done  = 1'b0;
  endtask

  initial begin
    int cyc;

    vecs[0]  = '{1'b1, 10'h000, 1'b1, 1'b1, 1'b1, W0,    1'b0};
    vecs[1]  = '{1'b1, 10'h004, 1'b1, 1'b1, 1'b1, W1,    1'b0};
    vecs[2]  = '{1'b1, 10'h008, 1'b1, 1'b1, 1'b1, NOP,   1'b0};
    vecs[3]  = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, NOP,   1'b0};
    vecs[4]  = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, NOP,   1'b0};
    vecs[5]  = '{1'b1, 10'h000, 1'b0, 1'b0, 1'b1, NOP,   1'b0};
    vecs[6]  = '{1'b1, 10'h000, 1'b1, 1'b1, 1'b1, W0,    1'b0};
    vecs[7]  = '{1'b1, 10'h100, 1'b1, 1'b1, 1'b1, OOR_D, OOR_F};
    vecs[8]  = '{1'b1, 10'h002, 1'b1, 1'b1, 1'b1, OOR_D, OOR_F};
    vecs[9]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, OOR_D, OOR_F};
    vecs[10] = '{1'b1, 10'h004, 1'b0, 1'b1, 1'b1, W1,    1'b0};
    vecs[11] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, W1,    1'b0};
    vecs[12] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, W1,    1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mode",        32'(mode),        32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("rst_prog_ready",  32'(prog_ready),  32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_data",  instr_data,       32'd0);
    chk("rst_instr_fault", 32'(instr_fault), 32'd0);

    // CLEAR length, with prog_done pulsed mid-clear to show it is ignored
    reset = 1'b0;
    wait_clear(1'b1, cyc);
    chk("clear_cycles",    32'(cyc),         32'd64);
    chk("load_mode",       32'(mode),        32'd1);
    chk("load_prog_ready", 32'(prog_ready),  32'd1);
    chk("load_fetch_rdy",  32'(fetch_ready), 32'd0);

    // Word 1 written in the same cycle as prog_done
    prog_write(6'd0, W0, 1'b0);
    prog_write(6'd1, W1, 1'b1);
    chk("run_mode",        32'(mode),        32'd2);
    chk("run_prog_ready",  32'(prog_ready),  32'd0);
    chk("run_fetch_ready", 32'(fetch_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      fetch_valid = vecs[i].fv;
      fetch_addr  = vecs[i].addr;
      instr_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_fetch_ready", i), 32'(fetch_ready), 32'(vecs[i].exp_fr));
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_v));
      chk($sformatf("v%0d_data", i),  instr_data,       vecs[i].exp_d);
      chk($sformatf("v%0d_fault", i), 32'(instr_fault), 32'(vecs[i].exp_f));
    end

    // Program port is ignored in RUN
    fetch_valid = 1'b0;
    prog_valid  = 1'b1;
    prog_addr   = 6'd2;
    prog_data   = 32'hdead_beef;
    #1;
    chk("run_prog_ready_hi", 32'(prog_ready), 32'd0);
    @(negedge clk);
    prog_valid  = 1'b0;
    fetch_valid = 1'b1;
    fetch_addr  = 10'h008;
    instr_ready = 1'b0;
    @(negedge clk);
    fetch_valid = 1'b0;
    chk("run_write_ignored", instr_data,       NOP);
    chk("pending_valid",     32'(instr_valid), 32'd1);

    // Asynchronous reset with a pending response
    reset = 1'b1;
    #1;
    chk("arst_valid",       32'(instr_valid), 32'd0);
    chk("arst_mode",        32'(mode),        32'd0);
    chk("arst_data",        instr_data,       32'd0);
    chk("arst_fetch_ready", 32'(fetch_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b0;
    instr_ready = 1'b1;
    wait_clear(1'b0, cyc);
    chk("reclear_cycles", 32'(cyc), 32'd64);
    prog_write(6'd0, 32'h1234_5678, 1'b1);

    fetch_valid = 1'b1;
    fetch_addr  = 10'h000;
    @(negedge clk);
    fetch_addr  = 10'h004;
    chk("reload_w0_valid", 32'(instr_valid), 32'd1);
    chk("reload_w0_data",  instr_data,       32'h1234_5678);
    @(negedge clk);
    fetch_valid = 1'b0;
    chk("reload_w1_cleared", instr_data, NOP);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imem_fetch_unit

`default_nettype wire
